// File: rtl/key_schedule_ctrl.sv
// Key schedule controller: packs USB RX bytes into NUM_KEYS key words, then presents
// NUM_ROUNDS round keys per start to the cipher core with a valid/ack handshake.
module key_schedule_ctrl #(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned KEY_W      = 32,
    parameter int unsigned NUM_ROUNDS = 8
) (
    input  logic                                  clk,
    input  logic                                  n_rst,
    input  logic                                  key_clear,
    input  logic [7:0]                            key_byte,
    input  logic                                  key_byte_valid,
    output logic                                  key_byte_ready,
    output logic                                  keys_loaded,
    input  logic                                  start,
    output logic                                  busy,
    output logic [KEY_W-1:0]                      round_key,
    output logic [$clog2(NUM_KEYS)-1:0]           key_idx,
    output logic [$clog2(NUM_ROUNDS+1)-1:0]       round_num,
    output logic                                  round_valid,
    input  logic                                  round_ack,
    output logic                                  last_round,
    output logic                                  done,
    output logic                                  err
);

    localparam int unsigned BPW  = KEY_W / 8;
    localparam int unsigned BP_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned KI_W = $clog2(NUM_KEYS);
    localparam int unsigned RN_W = $clog2(NUM_ROUNDS + 1);

    localparam logic [KI_W-1:0] LAST_KEY  = KI_W'(NUM_KEYS - 1);
    localparam logic [BP_W-1:0] LAST_BYTE = BP_W'(BPW - 1);
    localparam logic [RN_W-1:0] LAST_RND  = RN_W'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [KEY_W-1:0]  key_q [NUM_KEYS];
    logic [KEY_W-1:0]  key_d [NUM_KEYS];
    logic [KI_W-1:0]   word_q, word_d;
    logic [BP_W-1:0]   byte_pos_q, byte_pos_d;
    logic [KI_W-1:0]   key_idx_q, key_idx_d;
    logic [RN_W-1:0]   round_num_q, round_num_d;
    logic [KEY_W-1:0]  round_key_q, round_key_d;
    logic              ready_q, ready_d;
    logic              loaded_q, loaded_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              byte_ok_c;
    logic              ack_ok_c;

    assign byte_ok_c = key_byte_valid && (state_q == S_IDLE || state_q == S_LOAD);
    assign ack_ok_c  = round_ack && valid_q && (state_q == S_RUN);

    // Next-state, key storage and counter update
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        word_d      = word_q;
        byte_pos_d  = byte_pos_q;
        key_idx_d   = key_idx_q;
        round_num_d = round_num_q;
        err_d       = 1'b0;

        if (key_clear) begin
            state_d     = S_IDLE;
            word_d      = '0;
            byte_pos_d  = '0;
            key_idx_d   = '0;
            round_num_d = '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                key_d[k] = '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE, S_LOAD: begin
                    err_d = start;
                    if (byte_ok_c) begin
                        // First byte of a word lands in its most significant byte
                        for (int unsigned b = 0; b < BPW; b++) begin
                            if (byte_pos_q == BP_W'(b)) begin
                                key_d[word_q][(BPW-1-b)*8 +: 8] = key_byte;
                            end
                        end
                        state_d = S_LOAD;
                        if (byte_pos_q == LAST_BYTE) begin
                            byte_pos_d = '0;
                            if (word_q == LAST_KEY) begin
                                word_d  = '0;
                                state_d = S_READY;
                            end else begin
                                word_d = word_q + KI_W'(1);
                            end
                        end else begin
                            byte_pos_d = byte_pos_q + BP_W'(1);
                        end
                    end
                end
                S_READY: begin
                    if (start) begin
                        state_d     = S_RUN;
                        key_idx_d   = '0;
                        round_num_d = '0;
                    end
                end
                S_RUN: begin
                    if (ack_ok_c) begin
                        key_idx_d   = (key_idx_q == LAST_KEY) ? '0 : key_idx_q + KI_W'(1);
                        round_num_d = round_num_q + RN_W'(1);
                        if (round_num_q == LAST_RND) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_READY;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they appear registered with the state
    always_comb begin
        ready_d     = (state_d == S_IDLE) || (state_d == S_LOAD);
        loaded_d    = (state_d == S_READY) || (state_d == S_RUN) || (state_d == S_DONE);
        busy_d      = (state_d == S_RUN) || (state_d == S_DONE);
        valid_d     = (state_d == S_RUN);
        round_key_d = valid_d ? key_q[key_idx_d] : '0;
        last_d      = valid_d && (round_num_d == LAST_RND);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            byte_pos_q  <= '0;
            key_idx_q   <= '0;
            round_num_q <= '0;
            round_key_q <= '0;
            ready_q     <= 1'b1;
            loaded_q    <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                key_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            byte_pos_q  <= byte_pos_d;
            key_idx_q   <= key_idx_d;
            round_num_q <= round_num_d;
            round_key_q <= round_key_d;
            ready_q     <= ready_d;
            loaded_q    <= loaded_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                key_q[k] <= key_d[k];
            end
        end
    end

    assign key_byte_ready = ready_q;
    assign keys_loaded    = loaded_q;
    assign busy           = busy_q;
    assign round_key      = round_key_q;
    assign key_idx        = key_idx_q;
    assign round_num      = round_num_q;
    assign round_valid    = valid_q;
    assign last_round     = last_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl: expected round presentations are queued at start
// and popped as the DUT presents each round key.
module tb_key_schedule_ctrl;

    localparam int unsigned NUM_KEYS   = 4;
    localparam int unsigned KEY_W      = 32;
    localparam int unsigned NUM_ROUNDS = 8;
    localparam int unsigned BPW        = KEY_W / 8;
    localparam int unsigned NBYTES     = NUM_KEYS * BPW;
    localparam int unsigned KI_W       = $clog2(NUM_KEYS);
    localparam int unsigned RN_W       = $clog2(NUM_ROUNDS + 1);

    logic              clk = 1'b0;
    logic              n_rst;
    logic              key_clear;
    logic [7:0]        key_byte;
    logic              key_byte_valid;
    logic              key_byte_ready;
    logic              keys_loaded;
    logic              start;
    logic              busy;
    logic [KEY_W-1:0]  round_key;
    logic [KI_W-1:0]   key_idx;
    logic [RN_W-1:0]   round_num;
    logic              round_valid;
    logic              round_ack;
    logic              last_round;
    logic              done;
    logic              err;

    typedef struct {
        logic [KEY_W-1:0] key;
        logic [KI_W-1:0]  idx;
        logic [RN_W-1:0]  num;
        logic             last;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] bt [NBYTES];
    int         n_cmp = 0;
    int         n_mis = 0;

    key_schedule_ctrl #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_W     (KEY_W),
        .NUM_ROUNDS(NUM_ROUNDS)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .key_clear     (key_clear),
        .key_byte      (key_byte),
        .key_byte_valid(key_byte_valid),
        .key_byte_ready(key_byte_ready),
        .keys_loaded   (keys_loaded),
        .start         (start),
        .busy          (busy),
        .round_key     (round_key),
        .key_idx       (key_idx),
        .round_num     (round_num),
        .round_valid   (round_valid),
        .round_ack     (round_ack),
        .last_round    (last_round),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] word_of(input int w);
        logic [KEY_W-1:0] r = '0;
        for (int b = 0; b < int'(BPW); b++) begin
            r = {r[KEY_W-9:0], bt[w*int'(BPW)+b]};
        end
        return r;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, 64'(key_byte_ready), 64'd1);
        chk({tag, "_loaded"}, 64'(keys_loaded), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(round_valid), 64'd0);
        chk({tag, "_rkey"}, 64'(round_key), 64'd0);
        chk({tag, "_kidx"}, 64'(key_idx), 64'd0);
        chk({tag, "_rnum"}, 64'(round_num), 64'd0);
        chk({tag, "_last"}, 64'(last_round), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    task automatic load(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            chk("ld_ready", 64'(key_byte_ready), 64'd1);
            key_byte       = bt[i];
            key_byte_valid = 1'b1;
            tick();
        end
        key_byte_valid = 1'b0;
    endtask

    task automatic start_err(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_err"}, 64'(err), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ready"}, 64'(key_byte_ready), 64'd1);
        tick();
        chk({tag, "_err_end"}, 64'(err), 64'd0);
    endtask

    // hold_at: round whose ack is withheld 5 cycles; clear_at: round at which key_clear hits
    task automatic run_seq(input int hold_at, input int clear_at);
        exp_t e;
        for (int r = 0; r < int'(NUM_ROUNDS); r++) begin
            e.key  = word_of(r % int'(NUM_KEYS));
            e.idx  = KI_W'(r % int'(NUM_KEYS));
            e.num  = RN_W'(r);
            e.last = (r == int'(NUM_ROUNDS) - 1);
            sb.push_back(e);
        end
        round_ack = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < int'(NUM_ROUNDS); r++) begin
            e = sb.pop_front();
            chk("rv", 64'(round_valid), 64'd1);
            chk("busy_run", 64'(busy), 64'd1);
            chk("rkey", 64'(round_key), 64'(e.key));
            chk("kidx", 64'(key_idx), 64'(e.idx));
            chk("rnum", 64'(round_num), 64'(e.num));
            chk("last", 64'(last_round), 64'(e.last));
            if (r == clear_at) begin
                round_ack = 1'b0;
                key_clear = 1'b1;
                tick();
                key_clear = 1'b0;
                chk("clr_valid", 64'(round_valid), 64'd0);
                chk("clr_loaded", 64'(keys_loaded), 64'd0);
                chk("clr_ready", 64'(key_byte_ready), 64'd1);
                chk("clr_busy", 64'(busy), 64'd0);
                chk("clr_rkey", 64'(round_key), 64'd0);
                sb.delete();
                return;
            end
            if (r == hold_at) begin
                round_ack = 1'b0;
                repeat (5) begin
                    tick();
                    chk("hold_valid", 64'(round_valid), 64'd1);
                    chk("hold_rkey", 64'(round_key), 64'(e.key));
                    chk("hold_rnum", 64'(round_num), 64'(e.num));
                end
            end
            round_ack = 1'b1;
            tick();
        end
        round_ack = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_valid", 64'(round_valid), 64'd0);
        chk("done_rkey", 64'(round_key), 64'd0);
        tick();
        chk("post_done", 64'(done), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_loaded", 64'(keys_loaded), 64'd1);
        chk("post_ready", 64'(key_byte_ready), 64'd0);
    endtask

    initial begin
        n_rst          = 1'b0;
        key_clear      = 1'b0;
        key_byte       = 8'h00;
        key_byte_valid = 1'b0;
        start          = 1'b0;
        round_ack      = 1'b0;
        for (int i = 0; i < int'(NBYTES); i++) bt[i] = 8'(i);
        #12;
        check_idle("rst");
        tick();
        n_rst = 1'b1;
        tick();

        // start with no keys, then mid-load; load must continue intact
        start_err("err_empty");
        load(0, 4);
        start_err("err_partial");
        chk("partial_loaded", 64'(keys_loaded), 64'd0);
        load(5, int'(NBYTES) - 1);
        chk("loaded", 64'(keys_loaded), 64'd1);
        chk("ready_off", 64'(key_byte_ready), 64'd0);

        // bytes offered while keys are held must not be consumed
        key_byte       = 8'hAA;
        key_byte_valid = 1'b1;
        round_ack      = 1'b1;
        tick();
        key_byte_valid = 1'b0;
        round_ack      = 1'b0;
        chk("ign_ready", 64'(key_byte_ready), 64'd0);
        chk("ign_busy", 64'(busy), 64'd0);

        run_seq(-1, -1);
        run_seq(2, -1);
        run_seq(-1, 3);

        for (int i = 0; i < int'(NBYTES); i++) bt[i] = 8'(8'h10 + i);
        load(0, int'(NBYTES) - 1);
        chk("reload_loaded", 64'(keys_loaded), 64'd1);
        run_seq(-1, -1);

        // async reset during a partial load
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        for (int i = 0; i < int'(NBYTES); i++) bt[i] = 8'(i);
        load(0, 6);
        n_rst = 1'b0;
        #2;
        check_idle("arst");
        #2;
        n_rst = 1'b1;
        tick();
        load(0, int'(NBYTES) - 1);
        chk("arst_loaded", 64'(keys_loaded), 64'd1);
        run_seq(-1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
